// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports (instruction fetch, load/store) and the
// single-port data memory pins that the arbiter sits between.
//   if_*  : fetch request/address in, ack/read data out
//   dm_*  : load/store request, op codes, address, store data in; ack/load data out
//   mem_* : memory op codes, address, store data out; combinational read data in
//   busy  : arbiter is in ACCESS or RESP
// Modport slave is the arbiter side; modport master is the environment
// (requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic [2:0]        dm_read;
  logic [1:0]        dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;

  logic [2:0]        mem_read;
  logic [1:0]        mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_read, mem_write, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port data memory between instruction fetch and the
// load/store unit. A winning request is latched into a command register,
// driven onto the memory pins for exactly one ACCESS cycle, and the read
// data is returned from a response register with a one-cycle ack in RESP.
// Data accesses win ties, but after MAX_DATA_STREAK consecutive data grants
// with a fetch waiting, the fetch is served.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (requester ports, memory pins, busy)
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 2,
  parameter int ADDR_W          = 32
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              grant_any;
  logic              grant_data;

  logic [3:0]        streak;
  logic              cmd_is_data;
  logic [2:0]        cmd_read;
  logic [1:0]        cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [31:0]       rsp_data;

  // State register. Reset drops straight to IDLE, which also kills the
  // memory op codes of an in-flight access before its write edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, arbitration and per-state outputs. Requests are only
  // looked at in IDLE; in RESP the requester's req is still the old one.
  always_comb begin
    state_next    = state;
    grant_any     = 1'b0;
    grant_data    = 1'b0;
    bus.if_ack    = 1'b0;
    bus.dm_ack    = 1'b0;
    bus.busy      = 1'b0;
    bus.mem_read  = 3'b000;
    bus.mem_write = 2'b00;
    case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          grant_any  = 1'b1;
          grant_data = bus.dm_req && !(bus.if_req && (streak == STREAK_LIMIT));
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        bus.busy      = 1'b1;
        bus.mem_read  = cmd_read;
        bus.mem_write = cmd_write;
        state_next    = RESP;
      end
      RESP: begin
        bus.busy   = 1'b1;
        bus.if_ack = !cmd_is_data;
        bus.dm_ack = cmd_is_data;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command register. A store forces the read op to none so the memory
  // never sees a read and a write at once. A fetch leaves the store data
  // untouched so mem_wdata keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_is_data <= 1'b0;
      cmd_read    <= 3'b000;
      cmd_write   <= 2'b00;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
    end else if (grant_any) begin
      cmd_is_data <= grant_data;
      if (grant_data) begin
        cmd_write <= bus.dm_write;
        cmd_read  <= (bus.dm_write != 2'b00) ? 3'b000 : bus.dm_read;
        cmd_addr  <= bus.dm_addr;
        cmd_wdata <= bus.dm_wdata;
      end else begin
        cmd_write <= 2'b00;
        cmd_read  <= 3'b001;
        cmd_addr  <= bus.if_addr;
      end
    end
  end

  // Data-streak counter: counts data grants that overtook a waiting fetch,
  // saturating at 15; any grant that leaves no fetch waiting clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= 4'd0;
    end else if (grant_any) begin
      if (grant_data && bus.if_req) begin
        if (streak != 4'hF) begin
          streak <= streak + 4'd1;
        end
      end else begin
        streak <= 4'd0;
      end
    end
  end

  // Response register, loaded at the edge that ends ACCESS and held
  // between acks for both requesters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= 32'h0;
    end else if (state == ACCESS) begin
      rsp_data <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.if_rdata  = rsp_data;
  assign bus.dm_rdata  = rsp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter with a behavioural single-port memory (combinational
// read, negedge write). Expected responses are pushed to a scoreboard queue
// when a request is driven and popped by a monitor on every ack; scenario
// tasks add their own timing and pin checks.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  exp_t        sb[$];
  logic [31:0] mem[0:63];
  logic [31:0] ref_mem[0:63];
  logic [31:0] mem_word;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .MAX_DATA_STREAK(2),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational, extended reads
  always_comb begin
    mem_word      = mem[bus.mem_addr[7:2]];
    bus.mem_rdata = 32'h0;
    case (bus.mem_read)
      3'b001: bus.mem_rdata = mem_word;
      3'b010: bus.mem_rdata = 32'($signed(mem_word >> (16 * bus.mem_addr[1])) <<< 16) >>> 16;
      3'b011: bus.mem_rdata = (mem_word >> (16 * bus.mem_addr[1])) & 32'h0000FFFF;
      3'b100: bus.mem_rdata = 32'($signed(mem_word >> (8 * bus.mem_addr[1:0])) <<< 24) >>> 24;
      3'b101: bus.mem_rdata = (mem_word >> (8 * bus.mem_addr[1:0])) & 32'h000000FF;
      default: bus.mem_rdata = 32'h0;
    endcase
  end

  // Memory: initial contents and negedge writes
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[12] = 32'h11223344;
    forever begin
      @(negedge clk);
      case (bus.mem_write)
        2'b01: mem[bus.mem_addr[7:2]] = bus.mem_wdata;
        2'b10: mem[bus.mem_addr[7:2]][16 * bus.mem_addr[1] +: 16] = bus.mem_wdata[15:0];
        2'b11: mem[bus.mem_addr[7:2]][8 * bus.mem_addr[1:0] +: 8] = bus.mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  // Reference load result from the bench's own copy of memory
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = ref_mem[a[7:2]];
    h = a[1] ? w[31:16] : w[15:0];
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    case (op)
      3'b001: return w;
      3'b010: return {{16{h[15]}}, h};
      3'b011: return {16'h0, h};
      3'b100: return {{24{b[7]}}, b};
      3'b101: return {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  // Drive a load/store request and record what its ack should return
  task automatic drive_data(input logic [2:0] rd, input logic [1:0] wr,
                            input logic [31:0] a, input logic [31:0] d);
    bus.dm_read  = rd;
    bus.dm_write = wr;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    bus.dm_req   = 1'b1;
    case (wr)
      2'b01: ref_mem[a[7:2]] = d;
      2'b10: if (a[1]) ref_mem[a[7:2]][31:16] = d[15:0]; else ref_mem[a[7:2]][15:0] = d[15:0];
      2'b11: ref_mem[a[7:2]][8 * a[1:0] +: 8] = d[7:0];
      default: ;
    endcase
    if (wr != 2'b00 || rd == 3'b000) sb.push_back('{1'b1, 1'b0, 32'h0});
    else sb.push_back('{1'b1, 1'b1, ref_load(rd, a)});
  endtask

  task automatic release_data;
    @(posedge clk);
    #1;
    bus.dm_req   = 1'b0;
    bus.dm_read  = 3'b000;
    bus.dm_write = 2'b00;
  endtask

  // Counts negedges until the selected ack is seen, bounded at 20
  task automatic wait_ack(input bit is_data, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_data ? bus.dm_ack : bus.if_ack) && n < 20);
  endtask

  // Scoreboard monitor: every ack must match the oldest expectation
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (rst && (bus.if_ack || bus.dm_ack)) begin
      checks++;
      if (bus.if_ack && bus.dm_ack) begin
        errors++;
        $display("[TB] FAIL dual_ack: got if_ack=1 dm_ack=1 expected one ack");
      end else if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b expected none", bus.if_ack, bus.dm_ack);
      end else begin
        e = sb.pop_front();
        if (e.is_data !== bus.dm_ack) begin
          errors++;
          $display("[TB] FAIL grant_order: got dm_ack=%0b expected %0b", bus.dm_ack, e.is_data);
        end
        if (e.chk) begin
          checks++;
          act = bus.dm_ack ? bus.dm_rdata : bus.if_rdata;
          if (act !== e.data) begin
            errors++;
            $display("[TB] FAIL rdata: got %h expected %h", act, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 7;
    if ({bus.if_ack, bus.dm_ack, bus.busy} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.if_ack, bus.dm_ack, bus.busy});
    end
    if (bus.mem_read !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_mem_read: got %b expected 000", bus.mem_read);
    end
    if (bus.mem_write !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_mem_write: got %b expected 00", bus.mem_write);
    end
    if (bus.mem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr);
    end
    if (bus.mem_wdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata);
    end
    if (bus.if_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_if_rdata: got %h expected 0", bus.if_rdata);
    end
    if (bus.dm_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_dm_rdata: got %h expected 0", bus.dm_rdata);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_after_reset: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_fetch;
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    sb.push_back('{1'b0, 1'b1, ref_mem[4]});
    @(negedge clk);
    checks += 4;
    if (bus.mem_read !== 3'b001) begin
      errors++; $display("[TB] FAIL fetch_mem_read: got %b expected 001", bus.mem_read);
    end
    if (bus.mem_write !== 2'b00) begin
      errors++; $display("[TB] FAIL fetch_mem_write: got %b expected 00", bus.mem_write);
    end
    if (bus.mem_addr !== 32'h10) begin
      errors++; $display("[TB] FAIL fetch_mem_addr: got %h expected 10", bus.mem_addr);
    end
    if (bus.busy !== 1'b1 || bus.if_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL fetch_access: got busy=%b if_ack=%b expected 1 0", bus.busy, bus.if_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.if_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL fetch_latency: got if_ack=%b expected 1", bus.if_ack);
    end
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 3'b000 || bus.if_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL fetch_done: got mem_read=%b if_ack=%b expected 000 0", bus.mem_read, bus.if_ack);
    end
  endtask

  task automatic test_noop;
    int n;
    drive_data(3'b000, 2'b00, 32'h24, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 3'b000 || bus.mem_write !== 2'b00 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL noop_access: got rd=%b wr=%b busy=%b expected 000 00 1", bus.mem_read, bus.mem_write, bus.busy);
    end
    wait_ack(1'b1, n);
    checks++;
    if (n != 1) begin
      errors++; $display("[TB] FAIL noop_ack: got %0d cycles expected 1 after access", n);
    end
    release_data();
  endtask

  task automatic test_store_load;
    int n;
    @(negedge clk);
    drive_data(3'b000, 2'b01, 32'h20, 32'hDEADBEEF);
    @(negedge clk);
    checks += 3;
    if (bus.mem_read !== 3'b000 || bus.mem_write !== 2'b01) begin
      errors++; $display("[TB] FAIL sw_ops: got rd=%b wr=%b expected 000 01", bus.mem_read, bus.mem_write);
    end
    if (bus.mem_addr !== 32'h20) begin
      errors++; $display("[TB] FAIL sw_addr: got %h expected 20", bus.mem_addr);
    end
    if (bus.mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", bus.mem_wdata);
    end
    wait_ack(1'b1, n);
    checks++;
    if (n != 1) begin
      errors++; $display("[TB] FAIL sw_ack: got %0d cycles expected 1 after access", n);
    end
    @(posedge clk);
    #1;
    drive_data(3'b001, 2'b00, 32'h20, 32'h0);
    wait_ack(1'b1, n);
    checks++;
    if (n != 3) begin
      errors++; $display("[TB] FAIL lw_throughput: got %0d cycles expected 3", n);
    end
    release_data();
  endtask

  task automatic test_back_to_back;
    int t[6];
    int k;
    int guard;
    @(negedge clk);
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    drive_data(3'b001, 2'b00, 32'h20, 32'h0);
    void'(sb.pop_back());
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2) sb.push_back('{1'b0, 1'b1, ref_mem[4]});
      else sb.push_back('{1'b1, 1'b1, ref_load(3'b001, 32'h20)});
    end
    k = 0;
    guard = 0;
    while (k < 6 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (bus.if_ack || bus.dm_ack) begin
        t[k] = cyc;
        k++;
      end
    end
    checks++;
    if (k != 6) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d acks expected 6", k);
    end
    for (int i = 1; i < k; i++) begin
      checks++;
      if (t[i] - t[i-1] != 3) begin
        errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles expected 3", t[i] - t[i-1]);
      end
    end
    @(posedge clk);
    #1;
    bus.if_req   = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_read  = 3'b000;
  endtask

  task automatic test_byte_store;
    int n;
    @(negedge clk);
    drive_data(3'b000, 2'b11, 32'h30, 32'h000000AA);
    wait_ack(1'b1, n);
    checks++;
    if (n != 2) begin
      errors++; $display("[TB] FAIL sb_latency: got %0d cycles expected 2", n);
    end
    @(posedge clk);
    #1;
    drive_data(3'b101, 2'b00, 32'h30, 32'h0);
    wait_ack(1'b1, n);
    @(posedge clk);
    #1;
    drive_data(3'b001, 2'b00, 32'h30, 32'h0);
    wait_ack(1'b1, n);
    @(posedge clk);
    #1;
    drive_data(3'b010, 2'b00, 32'h32, 32'h0);
    wait_ack(1'b1, n);
    @(posedge clk);
    #1;
    drive_data(3'b100, 2'b00, 32'h30, 32'h0);
    wait_ack(1'b1, n);
    release_data();
    checks++;
    if (mem[12] !== 32'h112233AA) begin
      errors++; $display("[TB] FAIL sb_word: got %h expected 112233aa", mem[12]);
    end
  endtask

  task automatic test_reset_mid_store;
    @(negedge clk);
    bus.dm_read  = 3'b000;
    bus.dm_write = 2'b01;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'hCAFEF00D;
    bus.dm_req   = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (bus.mem_write !== 2'b01) begin
      errors++; $display("[TB] FAIL rst_pre_access: got wr=%b expected 01", bus.mem_write);
    end
    rst = 1'b0;
    #1;
    bus.dm_req   = 1'b0;
    bus.dm_write = 2'b00;
    checks += 4;
    if (bus.mem_write !== 2'b00 || bus.mem_read !== 3'b000) begin
      errors++; $display("[TB] FAIL rst_ops: got rd=%b wr=%b expected 000 00", bus.mem_read, bus.mem_write);
    end
    if ({bus.if_ack, bus.dm_ack, bus.busy} !== 3'b000) begin
      errors++; $display("[TB] FAIL rst_flags: got %b expected 000", {bus.if_ack, bus.dm_ack, bus.busy});
    end
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_pins: got addr=%h wdata=%h expected 0 0", bus.mem_addr, bus.mem_wdata);
    end
    if (bus.dm_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_rdata: got %h expected 0", bus.dm_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem[16] !== ref_mem[16]) begin
      errors++; $display("[TB] FAIL rst_no_write: got %h expected %h", mem[16], ref_mem[16]);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.dm_ack !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("[TB] FAIL rst_no_ack: got dm_ack=%b busy=%b expected 0 0", bus.dm_ack, bus.busy);
      end
    end
  endtask

  // Main sequence
  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.dm_req   = 1'b0;
    bus.dm_read  = 3'b000;
    bus.dm_write = 2'b00;
    bus.dm_addr  = 32'h0;
    bus.dm_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    ref_mem[12] = 32'h11223344;

    test_reset();
    test_fetch();
    test_noop();
    test_store_load();
    test_back_to_back();
    test_byte_store();
    test_reset_mid_store();

    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
